// File: rtl/lc3b_mem_arbiter.sv
// Two-port to one-port memory arbiter for the LC-3b core: one transaction at a time, round-robin between ports.
// Define ARB_FIXED_PRIO_EN to make port B (data) always win simultaneous requests.
module lc3b_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_byte_enable,
  output logic                a_resp,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_byte_enable,
  output logic                b_resp,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [0:0] PORT_A  = 1'b0;
  localparam logic [0:0] PORT_B  = 1'b1;
  localparam logic [0:0] OP_RD   = 1'b0;
  localparam logic [0:0] OP_WR   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [0:0]        owner_q, owner_d;
  logic [0:0]        last_grant_q, last_grant_d;
  logic [0:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   mask_q, mask_d;

  logic req_a, req_b, grant_b, busy;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;
  assign busy  = (state_q == ST_BUSY);

`ifdef ARB_FIXED_PRIO_EN
  assign grant_b = req_b;
`else
  // B wins only when A is idle or A was served last; reset leaves last_grant at B.
  assign grant_b = req_b & (~req_a | (last_grant_q == PORT_A));
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (req_a | req_b) begin
          state_d      = ST_BUSY;
          owner_d      = grant_b ? PORT_B : PORT_A;
          last_grant_d = grant_b ? PORT_B : PORT_A;
          // Write wins when a requester raises both strobes.
          op_d         = (grant_b ? b_write : a_write) ? OP_WR : OP_RD;
          addr_d       = grant_b ? b_address : a_address;
          wdata_d      = grant_b ? b_wdata : a_wdata;
          mask_d       = grant_b ? b_byte_enable : a_byte_enable;
        end
      end
      default: begin
        if (mem_resp) state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_A;
      last_grant_q <= PORT_B;
      op_q         <= OP_RD;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
    end
  end

  assign mem_read        = busy & (op_q == OP_RD);
  assign mem_write       = busy & (op_q == OP_WR);
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = mask_q;

  assign a_resp  = busy & mem_resp & (owner_q == PORT_A);
  assign b_resp  = busy & mem_resp & (owner_q == PORT_B);
  assign a_rdata = mem_rdata;
  assign b_rdata = mem_rdata;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed self-checking bench for lc3b_mem_arbiter; expectations follow ARB_FIXED_PRIO_EN when defined.
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_read, a_write, b_read, b_write;
  logic [15:0] a_address, b_address, a_wdata, b_wdata;
  logic [1:0]  a_byte_enable, b_byte_enable;
  logic        a_resp, b_resp;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  lc3b_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
    .a_byte_enable(a_byte_enable), .a_resp(a_resp), .a_rdata(a_rdata),
    .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
    .b_byte_enable(b_byte_enable), .b_resp(b_resp), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_b;
    rst = 1'b1;
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_address = '0; b_address = '0; a_wdata = '0; b_wdata = '0;
    a_byte_enable = '0; b_byte_enable = '0;
    mem_resp = 0; mem_rdata = '0;
    tick(); tick();
    check("rst_mem_read",  mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr",  mem_address, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_mem_be",    mem_byte_enable, 2'b11);
    check("rst_resps",     {a_resp, b_resp}, 2'b00);
    rst = 1'b0;

    // Port A read with memory latency of 3 cycles
    tick();
    a_read = 1; a_address = 16'h1000;
    #1 check("t1_idle_no_strobe", mem_read, 0);
    tick();
    check("t1_mem_read", mem_read, 1);
    check("t1_mem_addr", mem_address, 16'h1000);
    tick(); tick(); tick();
    check("t1_hold_no_resp", a_resp, 0);
    mem_resp = 1; mem_rdata = 16'hBEEF;
    #1;
    check("t1_a_resp",  a_resp, 1);
    check("t1_a_rdata", a_rdata, 16'hBEEF);
    check("t1_b_resp",  b_resp, 0);
    tick();
    check("t1_turnaround_read", mem_read, 0);
    check("t1_resp_one_cycle",  a_resp, 0);
    mem_resp = 0; a_read = 0;

    // Port B masked write
    b_write = 1; b_address = 16'h2002; b_wdata = 16'h00AB; b_byte_enable = 2'b01;
    tick();
    check("t2_mem_write", mem_write, 1);
    check("t2_mem_read",  mem_read, 0);
    check("t2_mem_addr",  mem_address, 16'h2002);
    check("t2_mem_wdata", mem_wdata, 16'h00AB);
    check("t2_mem_be",    mem_byte_enable, 2'b01);
    tick();
    check("t2_hold_write", mem_write, 1);
    mem_resp = 1;
    #1;
    check("t2_b_resp", b_resp, 1);
    check("t2_a_resp", a_resp, 0);
    tick();
    check("t2_idle_write", mem_write, 0);
    check("t2_b_resp_drop", b_resp, 0);
    mem_resp = 0; b_write = 0;

    // Both ports reading continuously: A,B,A,B (fixed priority: B every time)
    a_read = 1; a_address = 16'h3000;
    b_read = 1; b_address = 16'h4000;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_b = 1'b1;
`else
      exp_b = (i % 2 == 1);
`endif
      tick();
      check("t3_grant_addr", mem_address, exp_b ? 16'h4000 : 16'h3000);
      check("t3_strobe", mem_read, 1);
      tick();
      mem_resp = 1;
      #1;
      check("t3_resps", {a_resp, b_resp}, exp_b ? 2'b01 : 2'b10);
      tick();
      check("t3_turnaround", mem_read, 0);
      mem_resp = 0;
    end
    a_read = 0; b_read = 0;

    // B arrives while A is busy; A's mid-transaction address change is ignored
    a_read = 1; a_address = 16'h5000;
    tick();
    b_read = 1; b_address = 16'h6000; a_address = 16'h7777;
    #1 check("t4_addr_stable", mem_address, 16'h5000);
    tick();
    check("t4_addr_stable2", mem_address, 16'h5000);
    mem_resp = 1;
    #1 check("t4_resps_a", {a_resp, b_resp}, 2'b10);
    tick();
    mem_resp = 0; a_read = 0;
    check("t4_idle_gap", mem_read, 0);
    tick();
    check("t4_b_granted", mem_address, 16'h6000);
    check("t4_b_strobe",  mem_read, 1);
    mem_resp = 1;
    #1 check("t4_resps_b", {a_resp, b_resp}, 2'b01);
    tick();
    mem_resp = 0; b_read = 0;

    // Reset mid-transaction: strobe drops at once, no resp, A wins next tie
    a_read = 1; a_address = 16'h8000;
    tick();
    check("t5_busy", mem_read, 1);
    #2 rst = 1; mem_resp = 1;
    #1;
    check("t5_rst_strobe", mem_read, 0);
    check("t5_rst_resps",  {a_resp, b_resp}, 2'b00);
    check("t5_rst_addr",   mem_address, 16'h0000);
    tick();
    mem_resp = 0; rst = 0;
    b_read = 1; b_address = 16'h9000;
    tick();
`ifdef ARB_FIXED_PRIO_EN
    check("t5_tie_grant", mem_address, 16'h9000);
`else
    check("t5_tie_grant", mem_address, 16'h8000);
`endif
    mem_resp = 1;
    #1;
    tick();
    mem_resp = 0; a_read = 0; b_read = 0;

    // Read and write together: write wins; then spurious mem_resp in IDLE
    a_read = 1; a_write = 1; a_address = 16'hA000; a_wdata = 16'h1234; a_byte_enable = 2'b10;
    tick();
    check("t6_write_wins", {mem_read, mem_write}, 2'b01);
    check("t6_wdata", mem_wdata, 16'h1234);
    check("t6_be",    mem_byte_enable, 2'b10);
    mem_resp = 1;
    #1 check("t6_a_resp", a_resp, 1);
    tick();
    mem_resp = 0; a_read = 0; a_write = 0;
    tick();
    mem_resp = 1;
    #1;
    check("t6_spurious_resps", {a_resp, b_resp}, 2'b00);
    tick();
    check("t6_stays_idle", {mem_read, mem_write}, 2'b00);
    mem_resp = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Two-port to one-port memory arbiter for the LC-3b core.
- Shares a single physical memory interface between an instruction-fetch requester (port A) and a data requester (port B).
- Uses the same read/write/resp handshake the control FSM drives: a request is held until resp.
- Sits between the CPU and/or cache front-ends and the memory, and sequences one transaction at a time with round-robin fairness.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits; must be a multiple of 8. Byte-enable width is DATA_W/8.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_read, a_write  in  1 each  port A request strobes, held until a_resp.
- a_address  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_byte_enable  in  DATA_W/8  port A write mask.
- a_resp  out  1  port A completion pulse.
- a_rdata  out  DATA_W  port A read data, valid when a_resp=1.
- b_read, b_write, b_address, b_wdata, b_byte_enable, b_resp, b_rdata: same as port A, for port B.
- mem_read, mem_write  out  1 each  memory request strobes.
- mem_address  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_byte_enable  out  DATA_W/8  memory write mask.
- mem_resp  in  1  memory completion.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- States: IDLE, BUSY.
- Registers: owner (A/B), last_grant (A/B), op (rd/wr), addr_q, wdata_q, mask_q.
- Reset (async, any state): state=IDLE, last_grant=B, so A wins the first tie.
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=2'b11 pattern (all ones).
  - a_resp=b_resp=0.
  - An in-flight transaction is abandoned and no resp is issued.
- IDLE:
  - reqA = a_read|a_write; reqB = b_read|b_write.
  - Neither requests: stay in IDLE.
  - One requests: grant it.
  - Both request: grant the port not equal to last_grant; A wins ties unless the macro below is defined.
  - On grant: capture address, wdata, byte_enable and op into registers; owner<=granted port; last_grant<=granted port; next state BUSY.
  - If a requester asserts both read and write, write takes precedence.
- BUSY:
  - mem_read=(op==rd), mem_write=(op==wr), driven from registers.
  - Outputs are stable for the whole transaction, independent of requester inputs.
  - mem_resp=0: remain in BUSY, hold all outputs.
  - mem_resp=1: combinationally assert owner's resp for exactly that cycle; the other port's resp stays 0.
  - Next state IDLE, strobes drop next cycle.
- Read data: a_rdata=b_rdata=mem_rdata (passthrough). It is meaningful only alongside the matching resp.
- Latency:
  - Request seen in IDLE at cycle N → mem strobe high at N+1.
  - mem_resp at cycle M → requester resp at M.
  - IDLE at M+1, giving one mandatory turnaround cycle so requesters can drop stale strobes.
  - Back-to-back grants are therefore separated by at least one IDLE cycle.
- Requests arriving while BUSY are not lost: requesters hold strobes, and arbitration happens in the next IDLE.
- The non-owner's resp is never asserted. A resp is never asserted in IDLE.
- mem_resp seen in IDLE is ignored.
- Starvation bound: with both ports requesting continuously, grants alternate A,B,A,B.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port B (data) always wins simultaneous requests; last_grant is still updated but unused. A can starve while B requests continuously.
- Undefined: round-robin as above.

Test Plan:
- Reset then a_read=1 addr=0x1000, mem_resp returned 3 cycles after mem_read rises with mem_rdata=0xBEEF → mem_read high 1 cycle after request, mem_address=0x1000, a_resp pulses 1 cycle with a_rdata=0xBEEF, b_resp=0.
- b_write=1 addr=0x2002 wdata=0x00AB mask=01 → mem_write=1, mem_wdata=0x00AB, mem_byte_enable=01 until mem_resp; b_resp one cycle; then IDLE with mem_write=0.
- a_read and b_read both held continuously, mem_resp 1 cycle after each strobe → grant order A,B,A,B; ARB_FIXED_PRIO_EN build gives B,B,B with A never granted.
- b_read asserted while A is BUSY and A changes a_address mid-transaction → mem_address keeps A's captured value; B is granted in the IDLE after A's resp.
- rst pulsed mid-BUSY (between edges) → mem_read falls immediately, no resp asserted, first post-reset tie granted to A.
- a_read=a_write=1 simultaneously → write issued; spurious mem_resp in IDLE → no resp pulse.
